interrupt_sequencer: RTL and testbench
======================================

# interrupt_sequencer

- Sits directly upstream of the `control` FSM and supplies the byte `control` loads into IR at each instruction boundary.
- Synchronizes the NMI and IRQ pins, latches NMI edges and arbitrates reset/NMI/IRQ/BRK.
- At a fetch boundary it either passes the memory opcode through or injects a forced BRK (0x00).
- Holds the selected vector address and B-flag value stable until `control` signals that the vector has been fetched.

## Interface
Parameters:
- `RST_VEC`, 16'hFFFC, reset vector address
- `NMI_VEC`, 16'hFFFA, NMI vector address
- `IRQ_VEC`, 16'hFFFE, IRQ/BRK vector address

Ports:
- `clk` in 1: system clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `nmi_n` in 1: NMI pin, active-low, edge-triggered, asynchronous to `clk`.
- `irq_n` in 1: IRQ pin, active-low, level-sensitive, asynchronous to `clk`.
- `P_i` in 1: interrupt-disable flag from P.
- `fetch_req` in 1: one-cycle pulse from `control` in the cycle IR is loaded.
- `mem_data` in 8: opcode byte read from memory in the `fetch_req` cycle.
- `vec_done` in 1: one-cycle pulse from `control` when the vector high byte has been loaded.
- `ir_data` out 8: byte for IR.
- `int_inject` out 1: forced BRK; `control` suppresses the PC increment.
- `int_reset` out 1: reset sequence; `control` suppresses stack writes.
- `vec_addr` out 16: vector low-byte address; `control` reads `vec_addr` and `vec_addr+1`.
- `b_flag` out 1: B value to push with P.
- `busy` out 1: a service sequence is in progress.

## Operation
- Synchronizers:
  - Two flops each on `nmi_n` and `irq_n`, reset to 1.
  - Third flop `nmi_prev` on the synchronized NMI.
  - A falling edge (sync=0, prev=1) sets `nmi_pend`.
- `irq_act` = synchronized IRQ low AND `P_i`==0, evaluated combinationally.
- States: RST_PEND, IDLE, SVC.
  - Reset enters RST_PEND.
  - SVC is left only on `vec_done`, returning to IDLE.
- Decision in a `fetch_req` cycle outside SVC, first match wins:
  1. RST_PEND: inject; latch `vec_addr`=RST_VEC, `int_reset`=1, `b_flag`=0; go to SVC.
  2. `nmi_pend`: inject; latch NMI_VEC, `b_flag`=0; clear `nmi_pend`; go to SVC.
  3. `irq_act`: inject; latch IRQ_VEC, `b_flag`=0; go to SVC.
  4. `mem_data`==8'h00 (software BRK): pass through with no inject; latch IRQ_VEC, `b_flag`=1; go to SVC.
  5. Otherwise: pass through and stay in IDLE.
- While injecting, `ir_data`=8'h00; otherwise `ir_data`=`mem_data`.
- NMI hijack:
  - Applies in any SVC cycle with `vec_addr`==IRQ_VEC, `nmi_pend`=1 and `vec_done`=0.
  - Effect: `vec_addr` becomes NMI_VEC on the next edge and `nmi_pend` is cleared.
  - `b_flag` is unchanged, so a hijacked BRK still pushes B=1.
- `fetch_req` while in SVC is a protocol error: it is ignored, there is no inject, `ir_data`=`mem_data`, and state and outputs are unchanged.
- `vec_done` outside SVC is ignored.
- Simultaneous NMI edge and clear of `nmi_pend` (decision or hijack): the set wins and `nmi_pend` stays 1.
- An NMI edge in the `vec_done` cycle does not hijack; it remains pending.
- IRQ is not latched: if it is deasserted before a `fetch_req`, nothing is serviced.

## Timing
- Reset values: all sync flops 1; `nmi_pend`=0; state RST_PEND; `int_inject`=0; `int_reset`=0; `vec_addr`=RST_VEC; `b_flag`=0; `busy`=0.
- `ir_data` and `int_inject` are combinational from registered state, sync flops, `P_i`, `fetch_req` and `mem_data`. They are valid within the `fetch_req` cycle, and `int_inject`=0 when `fetch_req`=0.
- `vec_addr`, `b_flag`, `int_reset` and `busy` are registered. They update on the edge ending the `fetch_req` cycle and hold through the `vec_done` cycle inclusive.
- `busy`, `int_reset` and `b_flag` clear on the edge ending `vec_done`. `vec_addr` holds its last value.
- NMI latency: if `nmi_n` is first sampled low at edge k, `nmi_pend`=1 after edge k+2. A `fetch_req` in the cycle after edge k+2 services it.
- IRQ latency: if `irq_n` is sampled low at edge k, `irq_act` is visible from the cycle after edge k+1.
- `rst` asserted mid-SVC: immediate return to RST_PEND with all registers at their reset values. A pending NMI is lost.

## Test plan
- Release `rst`, first `fetch_req` with `mem_data`=8'hA9 -> `ir_data`=00, `int_inject`=1; next cycle `vec_addr`=FFFC, `int_reset`=1, `busy`=1; `vec_done` -> `busy`=0.
- In IDLE, `fetch_req` with `mem_data`=8'h00 -> `ir_data`=00, `int_inject`=0, `vec_addr`=FFFE, `b_flag`=1.
- Pulse `nmi_n` low for 1 cycle (held across one edge); `fetch_req` 3 cycles later -> inject, `vec_addr`=FFFA, `b_flag`=0, `nmi_pend` cleared. A second `fetch_req` after `vec_done` -> pass-through.
- `irq_n`=0 with `P_i`=1, `fetch_req` with `mem_data`=8'hEA -> `ir_data`=EA, no inject. Set `P_i`=0, next `fetch_req` -> inject, `vec_addr`=FFFE, `b_flag`=0.
- IRQ service in SVC, NMI edge 2 cycles before `vec_done` -> `vec_addr` switches FFFE→FFFA, `b_flag` stays 0, no second NMI service afterwards.
- NMI edge detected in the `vec_done` cycle of an IRQ service -> `vec_addr` stays FFFE; next `fetch_req` injects with FFFA. Also assert `rst` mid-SVC -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: synchronizes NMI/IRQ, arbitrates reset/NMI/IRQ/BRK at
// each instruction fetch boundary and holds the chosen vector until fetched.
module interrupt_sequencer #(
  parameter logic [15:0] RST_VEC = 16'hFFFC,
  parameter logic [15:0] NMI_VEC = 16'hFFFA,
  parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        P_i,
  input  logic        fetch_req,
  input  logic [7:0]  mem_data,
  input  logic        vec_done,
  output logic [7:0]  ir_data,
  output logic        int_inject,
  output logic        int_reset,
  output logic [15:0] vec_addr,
  output logic        b_flag,
  output logic        busy
);

  typedef enum logic [1:0] {
    RST_PEND = 2'd0,
    IDLE     = 2'd1,
    SVC      = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        nmi_s1_q, nmi_s2_q, nmi_prev_q;
  logic        irq_s1_q, irq_s2_q;
  logic        nmi_pend_q, nmi_pend_d;
  logic [15:0] vec_addr_q, vec_addr_d;
  logic        b_flag_q, b_flag_d;
  logic        int_reset_q, int_reset_d;
  logic        busy_q, busy_d;

  logic        irq_act, nmi_fall, nmi_clr;

  always_comb begin
    irq_act    = ~irq_s2_q & ~P_i;
    nmi_fall   = ~nmi_s2_q & nmi_prev_q;
    int_inject = fetch_req && (state_q != SVC) &&
                 ((state_q == RST_PEND) || nmi_pend_q || irq_act);
    ir_data    = int_inject ? 8'h00 : mem_data;

    state_d     = state_q;
    vec_addr_d  = vec_addr_q;
    b_flag_d    = b_flag_q;
    int_reset_d = int_reset_q;
    nmi_clr     = 1'b0;

    if (state_q == SVC) begin
      if (vec_done) begin
        state_d     = IDLE;
        b_flag_d    = 1'b0;
        int_reset_d = 1'b0;
      end else if (vec_addr_q == IRQ_VEC && nmi_pend_q) begin
        // NMI hijacks an IRQ/BRK vector fetch; B is kept as latched
        vec_addr_d = NMI_VEC;
        nmi_clr    = 1'b1;
      end
    end else if (fetch_req) begin
      if (state_q == RST_PEND) begin
        state_d     = SVC;
        vec_addr_d  = RST_VEC;
        int_reset_d = 1'b1;
        b_flag_d    = 1'b0;
      end else if (nmi_pend_q) begin
        state_d    = SVC;
        vec_addr_d = NMI_VEC;
        b_flag_d   = 1'b0;
        nmi_clr    = 1'b1;
      end else if (irq_act) begin
        state_d    = SVC;
        vec_addr_d = IRQ_VEC;
        b_flag_d   = 1'b0;
      end else if (mem_data == 8'h00) begin
        state_d    = SVC;
        vec_addr_d = IRQ_VEC;
        b_flag_d   = 1'b1;
      end
    end

    // A new edge in the same cycle as a clear keeps the NMI pending
    nmi_pend_d = nmi_fall | (nmi_pend_q & ~nmi_clr);
    busy_d     = (state_d == SVC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_s1_q    <= 1'b1;
      nmi_s2_q    <= 1'b1;
      nmi_prev_q  <= 1'b1;
      irq_s1_q    <= 1'b1;
      irq_s2_q    <= 1'b1;
      nmi_pend_q  <= 1'b0;
      state_q     <= RST_PEND;
      vec_addr_q  <= RST_VEC;
      b_flag_q    <= 1'b0;
      int_reset_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      nmi_s1_q    <= nmi_n;
      nmi_s2_q    <= nmi_s1_q;
      nmi_prev_q  <= nmi_s2_q;
      irq_s1_q    <= irq_n;
      irq_s2_q    <= irq_s1_q;
      nmi_pend_q  <= nmi_pend_d;
      state_q     <= state_d;
      vec_addr_q  <= vec_addr_d;
      b_flag_q    <= b_flag_d;
      int_reset_q <= int_reset_d;
      busy_q      <= busy_d;
    end
  end

  assign vec_addr  = vec_addr_q;
  assign b_flag    = b_flag_q;
  assign int_reset = int_reset_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: reset, BRK, NMI, IRQ, hijack and
// mid-service reset scenarios with hand-computed expectations.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        nmi_n, irq_n, P_i, fetch_req, vec_done;
  logic [7:0]  mem_data;
  logic [7:0]  ir_data;
  logic        int_inject, int_reset, b_flag, busy;
  logic [15:0] vec_addr;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  interrupt_sequencer #(
    .RST_VEC(16'hFFFC),
    .NMI_VEC(16'hFFFA),
    .IRQ_VEC(16'hFFFE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .nmi_n     (nmi_n),
    .irq_n     (irq_n),
    .P_i       (P_i),
    .fetch_req (fetch_req),
    .mem_data  (mem_data),
    .vec_done  (vec_done),
    .ir_data   (ir_data),
    .int_inject(int_inject),
    .int_reset (int_reset),
    .vec_addr  (vec_addr),
    .b_flag    (b_flag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Registered outputs: vec_addr, b_flag, int_reset, busy
  task automatic chk_regs(input string tag, input logic [15:0] va, input logic b,
                          input logic ir, input logic bs);
    chk({tag, ".vec_addr"},  vec_addr,          va);
    chk({tag, ".b_flag"},    {15'd0, b_flag},   {15'd0, b});
    chk({tag, ".int_reset"}, {15'd0, int_reset},{15'd0, ir});
    chk({tag, ".busy"},      {15'd0, busy},     {15'd0, bs});
  endtask

  task automatic chk_fetch(input string tag, input logic [7:0] ir, input logic inj);
    #1;
    chk({tag, ".ir_data"},    {8'd0, ir_data},     {8'd0, ir});
    chk({tag, ".int_inject"}, {15'd0, int_inject}, {15'd0, inj});
  endtask

  initial begin
    rst = 1'b1; nmi_n = 1'b1; irq_n = 1'b1; P_i = 1'b1;
    fetch_req = 1'b0; vec_done = 1'b0; mem_data = 8'h00;
    cyc(); cyc();
    chk_regs("reset", 16'hFFFC, 1'b0, 1'b0, 1'b0);
    chk_fetch("reset_nofetch", 8'h00, 1'b0);
    rst = 1'b0;
    cyc();

    // Reset service: first fetch injects BRK
    fetch_req = 1'b1; mem_data = 8'hA9;
    chk_fetch("rst_fetch", 8'h00, 1'b1);
    cyc(); fetch_req = 1'b0;
    chk_regs("rst_svc", 16'hFFFC, 1'b0, 1'b1, 1'b1);
    cyc(); vec_done = 1'b1;
    chk_regs("rst_vdone_hold", 16'hFFFC, 1'b0, 1'b1, 1'b1);
    cyc(); vec_done = 1'b0;
    chk_regs("rst_done", 16'hFFFC, 1'b0, 1'b0, 1'b0);

    // Software BRK, plus a fetch_req during SVC that must be ignored
    fetch_req = 1'b1; mem_data = 8'h00;
    chk_fetch("brk_fetch", 8'h00, 1'b0);
    cyc(); mem_data = 8'h55;
    chk_regs("brk_svc", 16'hFFFE, 1'b1, 1'b0, 1'b1);
    chk_fetch("svc_fetch_ignored", 8'h55, 1'b0);
    cyc(); fetch_req = 1'b0; vec_done = 1'b1;
    chk_regs("brk_svc_held", 16'hFFFE, 1'b1, 1'b0, 1'b1);
    cyc(); vec_done = 1'b0;
    chk_regs("brk_done", 16'hFFFE, 1'b0, 1'b0, 1'b0);

    // NMI pulse held across one edge (edge k); pending after edge k+2
    nmi_n = 1'b0;
    cyc(); nmi_n = 1'b1;                 // after edge k
    cyc();                               // after edge k+1: not yet pending
    fetch_req = 1'b1; mem_data = 8'hA9;
    chk_fetch("nmi_early", 8'hA9, 1'b0);
    cyc();                               // after edge k+2
    chk_fetch("nmi_fetch", 8'h00, 1'b1);
    cyc(); fetch_req = 1'b0;
    chk_regs("nmi_svc", 16'hFFFA, 1'b0, 1'b0, 1'b1);
    vec_done = 1'b1;
    cyc(); vec_done = 1'b0;
    fetch_req = 1'b1; mem_data = 8'hA9;
    chk_fetch("nmi_cleared", 8'hA9, 1'b0);
    cyc(); fetch_req = 1'b0;
    chk_regs("nmi_after", 16'hFFFA, 1'b0, 1'b0, 1'b0);

    // IRQ masked by P_i, then serviced
    irq_n = 1'b0; P_i = 1'b1;
    cyc(); cyc();
    fetch_req = 1'b1; mem_data = 8'hEA;
    chk_fetch("irq_masked", 8'hEA, 1'b0);
    cyc(); P_i = 1'b0;
    chk_regs("irq_masked_idle", 16'hFFFA, 1'b0, 1'b0, 1'b0);
    chk_fetch("irq_fetch", 8'h00, 1'b1);
    cyc(); fetch_req = 1'b0;
    chk_regs("irq_svc", 16'hFFFE, 1'b0, 1'b0, 1'b1);

    // NMI edge during IRQ service hijacks the vector
    nmi_n = 1'b0;
    cyc(); nmi_n = 1'b1;                 // after edge k
    cyc();                               // after k+1
    cyc(); irq_n = 1'b1;                 // after k+2: pending, hijack next edge
    chk_regs("hijack_pre", 16'hFFFE, 1'b0, 1'b0, 1'b1);
    cyc();
    chk_regs("hijack_post", 16'hFFFA, 1'b0, 1'b0, 1'b1);
    vec_done = 1'b1;
    cyc(); vec_done = 1'b0;
    chk_regs("hijack_done", 16'hFFFA, 1'b0, 1'b0, 1'b0);
    fetch_req = 1'b1; mem_data = 8'hA9;
    chk_fetch("hijack_no_second", 8'hA9, 1'b0);
    cyc(); fetch_req = 1'b0;

    // NMI edge detected in the vec_done cycle: no hijack, serviced next
    irq_n = 1'b0;
    cyc(); cyc();
    fetch_req = 1'b1; mem_data = 8'hEA;
    chk_fetch("irq2_fetch", 8'h00, 1'b1);
    cyc(); fetch_req = 1'b0; irq_n = 1'b1; nmi_n = 1'b0;
    cyc(); nmi_n = 1'b1;                 // after edge k
    cyc(); vec_done = 1'b1;              // after k+1: edge detected now
    chk_regs("late_nmi_vdone", 16'hFFFE, 1'b0, 1'b0, 1'b1);
    cyc(); vec_done = 1'b0;
    chk_regs("late_nmi_done", 16'hFFFE, 1'b0, 1'b0, 1'b0);
    fetch_req = 1'b1; mem_data = 8'hA9;
    chk_fetch("late_nmi_fetch", 8'h00, 1'b1);
    cyc(); fetch_req = 1'b0;
    chk_regs("late_nmi_svc", 16'hFFFA, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-service
    rst = 1'b1;
    #1;
    chk_regs("async_rst", 16'hFFFC, 1'b0, 1'b0, 1'b0);
    cyc(); rst = 1'b0;
    cyc();
    fetch_req = 1'b1; mem_data = 8'hEA;
    chk_fetch("rst2_fetch", 8'h00, 1'b1);
    cyc(); fetch_req = 1'b0;
    chk_regs("rst2_svc", 16'hFFFC, 1'b0, 1'b1, 1'b1);
    vec_done = 1'b1;
    cyc(); vec_done = 1'b0;
    fetch_req = 1'b1; mem_data = 8'hEA;
    chk_fetch("rst2_passthru", 8'hEA, 1'b0);
    cyc(); fetch_req = 1'b0;
    chk_regs("rst2_idle", 16'hFFFC, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
